bank_req_fifo: RTL and testbench
================================

# bank_req_fifo

Per-requester request buffer that sits directly upstream of the quad bank scheduler, one instance per M module (A–D). Accepts memory requests from its M module over a valid/ready handshake, queues them in a DEPTH-entry FIFO, presents the head entry to the scheduler, and retires it only on a cycle where the scheduler reports no conflict for this requester. For read requests, it returns the bank read data to the M module as a one-cycle response pulse.

## Interface
- ADDR_WIDTH, 13, global address width (matches scheduler)
- DATA_WIDTH, 32, data width
- DEPTH, 4, FIFO entries; power of two, ≥2
- lower_addr, 0, lowest global address owned by the downstream bank
- upper_addr, 4, highest global address owned by the downstream bank
- IDLE_ADDR, {ADDR_WIDTH{1'b1}}, address driven when empty; must lie outside [lower_addr, upper_addr]
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  M module request valid
- in_ready  out  1  FIFO can accept; = (count != DEPTH)
- in_addr  in  ADDR_WIDTH  request global address
- in_data  in  DATA_WIDTH  write data
- in_we  in  1  1 = write, 0 = read
- out_valid  out  1  head entry present; = (count != 0)
- out_addr  out  ADDR_WIDTH  head address to scheduler addrX; IDLE_ADDR when empty
- out_data  out  DATA_WIDTH  head write data to scheduler dataX; 0 when empty
- out_we  out  1  head write enable to scheduler write_enX; 0 when empty
- conflict  in  1  scheduler conflict flag for this requester (tie 0 for requester A)
- mem_data  in  DATA_WIDTH  scheduler dataMX return path
- rsp_valid  out  1  one-cycle read-response pulse
- rsp_data  out  DATA_WIDTH  read data, held until the next response
- err_oor  out  1  one-cycle pulse: request dropped because its address is out of range
- stall_cnt  out  8  consecutive conflicted cycles of current head, saturating

## Operation
- Storage: DEPTH × {addr, data, we}. Write pointer, read pointer, and count (0..DEPTH). Pointers wrap modulo DEPTH.
- Accept: in_valid && in_ready at posedge.
  - If lower_addr ≤ in_addr ≤ upper_addr (both comparisons unsigned, full ADDR_WIDTH), the entry is enqueued.
  - Otherwise it is not enqueued, and err_oor=1 on the next cycle. The handshake still completes.
- Retire (pop): out_valid && !conflict at posedge.
  - On pop of a read entry: rsp_data <= mem_data and rsp_valid <= 1.
  - On pop of a write entry: rsp_valid <= 0 and rsp_data is unchanged.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any count except 0, where no pop is possible. At count == DEPTH, in_ready=0, so no push occurs even if a pop does (no pass-through).
- stall_cnt:
  - Cleared on pop and whenever the FIFO is empty.
  - Incremented while out_valid && conflict.
  - Saturates at 255.
- Head outputs (out_*) are combinational from the read pointer, so there is no bubble between back-to-back entries.

## Timing
- Reset (rst_n low, async) forces:
  - count=0 and pointers=0
  - in_ready=1, out_valid=0, out_addr=IDLE_ADDR, out_data=0, out_we=0
  - rsp_valid=0, rsp_data=0, err_oor=0, stall_cnt=0
  - Storage contents are don't-care.
- The scheduler evaluates on negedge and registers conflict there. The conflict value sampled at posedge N therefore refers to the head that was presented from posedge N-1.
- Enqueue-to-present latency: a request accepted at posedge N appears on out_* after posedge N if the FIFO was empty, giving minimum head residency of 1 cycle.
- Read latency: head presented after posedge N, popped at posedge N+1 with no conflict, so rsp_valid=1 during cycle N+1..N+2.
- Reset asserted mid-operation discards all entries. No response is generated for discarded entries.
- in_* may change freely while in_ready=0. Nothing is captured.

## Test plan
- Reset/idle: hold rst_n=0, then release. Check out_addr=IDLE_ADDR, out_valid=0, in_ready=1, and all other outputs 0.
- Read, no conflict: with lower_addr=0/upper_addr=4, push {addr=3, we=0}, conflict=0, mem_data=0xDEADBEEF. Check out_addr=3 one cycle after accept, rsp_valid pulses once with rsp_data=0xDEADBEEF, and out_valid returns to 0.
- Conflict hold: push {addr=2, we=1, data=0x55}, hold conflict=1 for 3 cycles. Check out_* is stable, stall_cnt reaches 3, there is no pop, and after conflict drops the entry retires with stall_cnt=0 and no rsp_valid.
- Full/wrap: hold conflict=1 and push 5 requests. Check in_ready=0 after the 4th and that the 5th is not captured. Release conflict, then push 4 more during drain. Check FIFO order 1..4 then 5..8 across the pointer wrap, with simultaneous push/pop keeping count constant.
- Out of range: push addr=7 with upper_addr=4. Check err_oor pulses one cycle, count stays 0, and in_ready stays 1.
- Async reset mid-queue: with 3 entries queued, pulse rst_n low between clock edges. Check outputs go to reset values immediately, and there is no rsp_valid afterward.

Source files
------------

// File: rtl/bank_req_fifo_if.sv
// Request/response bundle between an M module, its bank_req_fifo and the bank scheduler.
// The slave modport is the FIFO side; the master modport is the requester/scheduler side.
interface bank_req_fifo_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_we;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_we;
  logic                  conflict;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  err_oor;
  logic [7:0]            stall_cnt;

  modport master (
    output in_valid, in_addr, in_data, in_we, conflict, mem_data,
    input  in_ready, out_valid, out_addr, out_data, out_we,
           rsp_valid, rsp_data, err_oor, stall_cnt
  );

  modport slave (
    input  in_valid, in_addr, in_data, in_we, conflict, mem_data,
    output in_ready, out_valid, out_addr, out_data, out_we,
           rsp_valid, rsp_data, err_oor, stall_cnt
  );
endinterface

// File: rtl/bank_req_fifo.sv
// Per-requester request FIFO ahead of the bank scheduler: combinational head, retire on a conflict-free edge,
// read data returned as a one-cycle pulse after retire; in_ready drops only when all DEPTH entries are held.
module bank_req_fifo #(
  parameter int                    ADDR_WIDTH = 13,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] lower_addr = '0,
  parameter logic [ADDR_WIDTH-1:0] upper_addr = ADDR_WIDTH'(4),
  parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR  = {ADDR_WIDTH{1'b1}}
) (
  input logic            clk,
  input logic            rst_n,
  bank_req_fifo_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  we;
  } entry_t;

  entry_t                storage [DEPTH];
  entry_t                head;
  logic [PTR_W-1:0]      wrPtr;
  logic [PTR_W-1:0]      rdPtr;
  logic [CNT_W-1:0]      count;
  logic [ADDR_WIDTH-1:0] addrOffset;
  logic                  inRange;
  logic                  notEmpty;
  logic                  accept;
  logic                  doPush;
  logic                  doPop;

  // One unsigned compare covers both bounds: addresses below lower_addr wrap to huge offsets.
  assign addrOffset = bus.in_addr - lower_addr;
  assign inRange    = (addrOffset <= (upper_addr - lower_addr));

  assign notEmpty = (count != '0);
  assign accept   = bus.in_valid && bus.in_ready;
  assign doPush   = accept && inRange;
  assign doPop    = notEmpty && !bus.conflict;
  assign head     = storage[rdPtr];

  assign bus.in_ready  = (count != FULL);
  assign bus.out_valid = notEmpty;
  assign bus.out_addr  = notEmpty ? head.addr : IDLE_ADDR;
  assign bus.out_data  = notEmpty ? head.data : '0;
  assign bus.out_we    = notEmpty && head.we;

  always_ff @(posedge clk) begin
    if (doPush) begin
      storage[wrPtr] <= '{addr: bus.in_addr, data: bus.in_data, we: bus.in_we};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.err_oor   <= 1'b0;
      bus.stall_cnt <= '0;
    end else begin
      bus.err_oor   <= accept && !inRange;
      bus.rsp_valid <= doPop && !head.we;
      if (doPop && !head.we) begin
        bus.rsp_data <= bus.mem_data;
      end
      // Counts only conflicted cycles of the entry currently at the head.
      if (doPop || !notEmpty) begin
        bus.stall_cnt <= '0;
      end else if (bus.conflict && (bus.stall_cnt != 8'hFF)) begin
        bus.stall_cnt <= bus.stall_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_bank_req_fifo.sv
// Scoreboard bench for bank_req_fifo: a queue model tracks accepted entries and expected responses,
// checked every negedge, plus directed checks on reset, stall, full/wrap, range and async reset.
module tb_bank_req_fifo;
  localparam int DEPTH = 4;
  localparam int LOWER = 0;
  localparam int UPPER = 4;
  localparam logic [12:0] IDLE = 13'h1FFF;

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
    logic        we;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nFail   = 0;

  bank_req_fifo_if #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) bus ();

  bank_req_fifo #(
    .ADDR_WIDTH(13), .DATA_WIDTH(32), .DEPTH(DEPTH),
    .lower_addr(13'(LOWER)), .upper_addr(13'(UPPER)), .IDLE_ADDR(IDLE)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, advanced on the same edges as the DUT.
  ent_t        q[$];
  logic [31:0] popLog[$];
  bit          expRspVld  = 1'b0;
  logic [31:0] expRspData = '0;
  bit          expErr     = 1'b0;
  int          expStall   = 0;
  bit          mRng, mReady, mPop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      expRspVld  = 1'b0;
      expRspData = '0;
      expErr     = 1'b0;
      expStall   = 0;
    end else begin
      mRng   = (int'(bus.in_addr) >= LOWER) && (int'(bus.in_addr) <= UPPER);
      mReady = (q.size() < DEPTH);
      mPop   = (q.size() != 0) && !bus.conflict;
      expErr = bus.in_valid && mReady && !mRng;
      if (mPop && !q[0].we) begin
        expRspVld  = 1'b1;
        expRspData = bus.mem_data;
      end else begin
        expRspVld = 1'b0;
      end
      if (mPop || q.size() == 0) expStall = 0;
      else if (bus.conflict && expStall < 255) expStall++;
      if (mPop) void'(q.pop_front());
      if (bus.in_valid && mReady && mRng)
        q.push_back('{addr: bus.in_addr, data: bus.in_data, we: bus.in_we});
    end
  end

  always @(negedge clk) begin
    check("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
    check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_addr", 32'(bus.out_addr), 32'(q[0].addr));
      check("out_data", bus.out_data, q[0].data);
      check("out_we", 32'(bus.out_we), 32'(q[0].we));
    end else begin
      check("idle_addr", 32'(bus.out_addr), 32'(IDLE));
      check("idle_data", bus.out_data, 32'd0);
      check("idle_we", 32'(bus.out_we), 32'd0);
    end
    check("rsp_valid", 32'(bus.rsp_valid), 32'(expRspVld));
    check("rsp_data", bus.rsp_data, expRspData);
    check("err_oor", 32'(bus.err_oor), 32'(expErr));
    check("stall_cnt", 32'(bus.stall_cnt), 32'(expStall));
    if (rst_n && bus.out_valid && !bus.conflict) popLog.push_back(bus.out_data);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pushReq(input logic [12:0] a, input logic [31:0] d, input logic w);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.in_we    = w;
    while (!bus.in_ready && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) check("push_timeout", 32'(n), 32'd0);
    cyc();
    bus.in_valid = 1'b0;
  endtask

  task automatic checkResetOutputs(input string pfx);
    check({pfx, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({pfx, "_out_addr"}, 32'(bus.out_addr), 32'(IDLE));
    check({pfx, "_out_data"}, bus.out_data, 32'd0);
    check({pfx, "_out_we"}, 32'(bus.out_we), 32'd0);
    check({pfx, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({pfx, "_rsp_data"}, bus.rsp_data, 32'd0);
    check({pfx, "_err_oor"}, 32'(bus.err_oor), 32'd0);
    check({pfx, "_stall"}, 32'(bus.stall_cnt), 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.in_we    = 1'b0;
    bus.conflict = 1'b0;
    bus.mem_data = '0;

    // Reset / idle
    repeat (3) cyc();
    checkResetOutputs("rst");
    rst_n = 1'b1;
    cyc();

    // Read without conflict
    bus.mem_data = 32'hDEADBEEF;
    pushReq(13'd3, 32'h0, 1'b0);
    check("rd_head_addr", 32'(bus.out_addr), 32'd3);
    check("rd_head_valid", 32'(bus.out_valid), 32'd1);
    cyc();
    check("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rd_rsp_data", bus.rsp_data, 32'hDEADBEEF);
    check("rd_empty", 32'(bus.out_valid), 32'd0);
    cyc();
    check("rd_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

    // Conflict hold on a write
    bus.conflict = 1'b1;
    pushReq(13'd2, 32'h55, 1'b1);
    repeat (3) cyc();
    check("hold_stall3", 32'(bus.stall_cnt), 32'd3);
    check("hold_addr", 32'(bus.out_addr), 32'd2);
    check("hold_data", bus.out_data, 32'h55);
    check("hold_valid", 32'(bus.out_valid), 32'd1);
    bus.conflict = 1'b0;
    cyc();
    check("hold_retired", 32'(bus.out_valid), 32'd0);
    check("hold_stall0", 32'(bus.stall_cnt), 32'd0);
    check("hold_no_rsp", 32'(bus.rsp_valid), 32'd0);

    // Stall counter saturation
    bus.conflict = 1'b1;
    pushReq(13'd1, 32'h77, 1'b1);
    repeat (260) cyc();
    check("stall_sat", 32'(bus.stall_cnt), 32'd255);
    bus.conflict = 1'b0;
    cyc();
    check("stall_sat_clr", 32'(bus.stall_cnt), 32'd0);

    // Full, rejected push, then push during drain across the pointer wrap
    popLog.delete();
    bus.conflict = 1'b1;
    for (int id = 1; id <= 4; id++) pushReq(13'(id % 5), 32'(id), 1'b1);
    check("full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_addr  = 13'd1;
    bus.in_data  = 32'd99;
    bus.in_we    = 1'b1;
    repeat (2) begin
      cyc();
      check("full_blocked", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.conflict = 1'b0;
    cyc();
    check("drain_ready", 32'(bus.in_ready), 32'd1);
    for (int id = 5; id <= 8; id++) begin
      pushReq(13'(id % 5), 32'(id), 1'b1);
      check("drain_const", 32'(bus.in_ready), 32'd1);
    end
    repeat (5) cyc();
    check("order_count", 32'(popLog.size()), 32'd8);
    for (int k = 0; k < popLog.size() && k < 8; k++) check("order", popLog[k], 32'(k + 1));

    // Out of range and boundary addresses
    pushReq(13'd7, 32'h1, 1'b0);
    check("oor_err", 32'(bus.err_oor), 32'd1);
    check("oor_empty", 32'(bus.out_valid), 32'd0);
    check("oor_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    check("oor_pulse", 32'(bus.err_oor), 32'd0);
    pushReq(13'd5, 32'h2, 1'b0);
    check("oor5_err", 32'(bus.err_oor), 32'd1);
    bus.mem_data = 32'hA5A5_0004;
    pushReq(13'd4, 32'h3, 1'b0);
    check("edge4_err", 32'(bus.err_oor), 32'd0);
    check("edge4_addr", 32'(bus.out_addr), 32'd4);
    cyc();
    check("edge4_rsp", bus.rsp_data, 32'hA5A5_0004);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_addr  = 13'($urandom_range(0, 7));
      bus.in_data  = $urandom;
      bus.in_we    = 1'($urandom_range(0, 1));
      bus.conflict = ($urandom_range(0, 3) == 0);
      bus.mem_data = $urandom;
      cyc();
    end
    bus.in_valid = 1'b0;
    bus.conflict = 1'b0;
    repeat (6) cyc();

    // Async reset with entries queued
    bus.conflict = 1'b1;
    for (int id = 1; id <= 3; id++) pushReq(13'(id), 32'(id), 1'b0);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("arst");
    cyc();
    cyc();
    rst_n = 1'b1;
    bus.conflict = 1'b0;
    repeat (4) begin
      cyc();
      check("arst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check("arst_empty", 32'(bus.out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
